regfile_decoded: RTL and testbench

Parametrised register file with a one-hot decoded write port, two combinational read ports, optional write-to-read bypass, optional hardwired-zero register 0, and a sequential clear sweep. It generalises the fixed 5-to-32 write-enable decode into a self-contained storage block for the datapath. The CPU core uses it as its general-purpose register file, and test/debug logic uses it for bulk clearing.

---
 rtl/regfile_decoded_pkg.sv | 11 +
 rtl/regfile_decoded_onehot_decoder.sv | 16 +
 rtl/regfile_decoded.sv | 116 +++++++++++
 tb/tb_regfile_decoded.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_decoded_pkg.sv
// Shared types for the decoded register file and its clear sweep.
package regfile_decoded_pkg;

  // Clear-sweep controller states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SWEEP = 2'd1,
    ST_DONE  = 2'd2
  } clr_state_t;

endpackage

// File: rtl/regfile_decoded_onehot_decoder.sv
// Binary address to one-hot enable decoder, gated by a single enable.
module onehot_decoder #(
  parameter int AW = 5
) (
  input  logic [AW-1:0]      addr,
  input  logic               en,
  output logic [2**AW-1:0]   y
);

  // Exactly one bit set when enabled, all zero otherwise.
  always_comb begin
    y = '0;
    if (en) y[addr] = 1'b1;
  end

endmodule

// File: rtl/regfile_decoded.sv
// Register file with one-hot decoded write, two combinational read ports,
// optional bypass, optional hardwired-zero register 0 and a clear sweep.
//
// state    | meaning
// ---------+--------------------------------------------------------
// ST_IDLE  | normal operation, writes accepted, clr_req sampled
// ST_SWEEP | clearing reg[ptr] each cycle, writes refused
// ST_DONE  | sweep finished, clr_done high for this one cycle
module regfile_decoded
  import regfile_decoded_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int AW       = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  output logic             wr_ready,
  input  logic [AW-1:0]    rd_addr_a,
  input  logic [AW-1:0]    rd_addr_b,
  output logic [WIDTH-1:0] rd_data_a,
  output logic [WIDTH-1:0] rd_data_b,
  input  logic             clr_req,
  output logic             clr_busy,
  output logic             clr_done
);

  localparam int DEPTH = 2**AW;

  clr_state_t state, state_next;
  logic [AW-1:0] ptr, ptr_next;

  logic                         wr_fire;
  logic [DEPTH-1:0]             wr_sel;
  logic [DEPTH-1:0]             sweep_sel;
  logic [DEPTH-1:0][WIDTH-1:0]  mem;

  // Status outputs come straight from the registered state.
  assign wr_ready = (state == ST_IDLE);
  assign clr_busy = (state != ST_IDLE);
  assign clr_done = (state == ST_DONE);
  assign wr_fire  = wr_en && wr_ready;

  onehot_decoder #(.AW(AW)) u_wr_dec (
    .addr (wr_addr),
    .en   (wr_fire),
    .y    (wr_sel)
  );

  assign sweep_sel = (state == ST_SWEEP) ? (DEPTH'(1) << ptr) : '0;

  for (genvar g = 0; g < DEPTH; g++) begin : g_reg
    if (ZERO_REG != 0 && g == 0) begin : g_zero
      assign mem[g] = '0;
    end else begin : g_store
      logic [WIDTH-1:0] q;
      // Sweep clear wins over a write; both never coincide since writes stall in SWEEP.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)            q <= '0;
        else if (sweep_sel[g]) q <= '0;
        else if (wr_sel[g])    q <= wr_data;
      end
      assign mem[g] = q;
    end
  end

  // Clear controller state and sweep pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      ptr   <= '0;
    end else begin
      state <= state_next;
      ptr   <= ptr_next;
    end
  end

  // Next state: pointer advances until the last register is cleared, never wraps.
  always_comb begin
    state_next = state;
    ptr_next   = ptr;
    case (state)
      ST_IDLE: begin
        if (clr_req) begin
          state_next = ST_SWEEP;
          ptr_next   = '0;
        end
      end
      ST_SWEEP: begin
        if (ptr == AW'(DEPTH-1)) state_next = ST_DONE;
        else                     ptr_next   = ptr + AW'(1);
      end
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Read port A: zero register beats bypass, bypass beats storage.
  always_comb begin
    rd_data_a = mem[rd_addr_a];
    if (BYPASS != 0 && wr_fire && wr_addr == rd_addr_a) rd_data_a = wr_data;
    if (ZERO_REG != 0 && rd_addr_a == '0)               rd_data_a = '0;
  end

  // Read port B: same priority as port A.
  always_comb begin
    rd_data_b = mem[rd_addr_b];
    if (BYPASS != 0 && wr_fire && wr_addr == rd_addr_b) rd_data_b = wr_data;
    if (ZERO_REG != 0 && rd_addr_b == '0)               rd_data_b = '0;
  end

endmodule

// File: tb/tb_regfile_decoded.sv
// Bench for regfile_decoded: two instances (zero-reg+bypass, plain) driven in
// parallel, checked against an array model every cycle plus literal pins.
module tb_regfile_decoded;
  localparam int WIDTH = 32;
  localparam int AW    = 5;
  localparam int DEPTH = 32;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic [AW-1:0]    rd_addr_a, rd_addr_b;
  logic             clr_req;

  logic             wr_ready_zb, clr_busy_zb, clr_done_zb;
  logic [WIDTH-1:0] rd_a_zb, rd_b_zb;
  logic             wr_ready_pl, clr_busy_pl, clr_done_pl;
  logic [WIDTH-1:0] rd_a_pl, rd_b_pl;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  logic [WIDTH-1:0] mz [DEPTH];
  logic [WIDTH-1:0] mp [DEPTH];
  int phase = -1;

  regfile_decoded #(.WIDTH(WIDTH), .AW(AW), .ZERO_REG(1), .BYPASS(1)) u_zb (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_ready(wr_ready_zb), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(rd_a_zb), .rd_data_b(rd_b_zb), .clr_req(clr_req),
    .clr_busy(clr_busy_zb), .clr_done(clr_done_zb));

  regfile_decoded #(.WIDTH(WIDTH), .AW(AW), .ZERO_REG(0), .BYPASS(0)) u_pl (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_ready(wr_ready_pl), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(rd_a_pl), .rd_data_b(rd_b_pl), .clr_req(clr_req),
    .clr_busy(clr_busy_pl), .clr_done(clr_done_pl));

  always #5 clk = ~clk;

  task automatic chk(string name, logic [WIDTH-1:0] act, logic [WIDTH-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: phase -1 = idle, 0..DEPTH-1 = clearing that index, DEPTH = done cycle.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin mz[i] = '0; mp[i] = '0; end
      phase = -1;
    end else if (phase < 0) begin
      if (wr_en) begin
        if (wr_addr != 0) mz[wr_addr] = wr_data;
        mp[wr_addr] = wr_data;
      end
      if (clr_req) phase = 0;
    end else if (phase < DEPTH) begin
      mz[phase] = '0;
      mp[phase] = '0;
      phase++;
    end else begin
      phase = -1;
    end
  end

  function automatic logic [WIDTH-1:0] exp_rd(bit zb, logic [AW-1:0] a);
    if (zb && a == 0) return '0;
    if (zb && wr_en && phase < 0 && wr_addr == a) return wr_data;
    return zb ? mz[a] : mp[a];
  endfunction

  // Compare both instances against the model in the middle of every cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("zb_rd_a", rd_a_zb, exp_rd(1'b1, rd_addr_a));
      chk("zb_rd_b", rd_b_zb, exp_rd(1'b1, rd_addr_b));
      chk("pl_rd_a", rd_a_pl, exp_rd(1'b0, rd_addr_a));
      chk("pl_rd_b", rd_b_pl, exp_rd(1'b0, rd_addr_b));
      chk("zb_ready", WIDTH'(wr_ready_zb), WIDTH'(phase < 0));
      chk("pl_ready", WIDTH'(wr_ready_pl), WIDTH'(phase < 0));
      chk("zb_busy",  WIDTH'(clr_busy_zb), WIDTH'(phase >= 0));
      chk("pl_busy",  WIDTH'(clr_busy_pl), WIDTH'(phase >= 0));
      chk("zb_done",  WIDTH'(clr_done_zb), WIDTH'(phase == DEPTH));
      chk("pl_done",  WIDTH'(clr_done_pl), WIDTH'(phase == DEPTH));
    end
  end

  task automatic set(logic en, logic [AW-1:0] wa, logic [WIDTH-1:0] wd,
                     logic [AW-1:0] ra, logic [AW-1:0] rb, logic clr);
    wr_en = en; wr_addr = wa; wr_data = wd;
    rd_addr_a = ra; rd_addr_b = rb; clr_req = clr;
    @(negedge clk); #2;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  int busy_cnt, done_cnt, done_at, ready_low;

  initial begin
    wr_en = 0; wr_addr = '0; wr_data = '0; rd_addr_a = '0; rd_addr_b = '0; clr_req = 0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk_en = 1'b1;

    // Reset state.
    set(0, 0, 0, 5, 31, 0);
    chk("rst_ready", WIDTH'(wr_ready_zb), 1);
    chk("rst_busy",  WIDTH'(clr_busy_zb), 0);
    chk("rst_done",  WIDTH'(clr_done_pl), 0);
    chk("rst_rd_a",  rd_a_pl, 0);
    chk("rst_rd_b",  rd_b_pl, 0);
    tick();

    // Basic write, read the next cycle.
    set(1, 5, 32'hDEADBEEF, 4, 6, 0);
    tick();
    set(0, 0, 0, 5, 6, 0);
    chk("wr5_a", rd_a_zb, 32'hDEADBEEF);
    chk("wr6_b", rd_b_zb, 32'h0);
    chk("wr5_pl", rd_a_pl, 32'hDEADBEEF);
    tick();

    // Hardwired zero register.
    set(1, 0, 32'h1234, 0, 0, 0);
    chk("zero_same_a", rd_a_zb, 0);
    chk("zero_same_b", rd_b_zb, 0);
    tick();
    set(0, 0, 0, 0, 0, 0);
    chk("zero_after_a", rd_a_zb, 0);
    chk("zero_after_b", rd_b_zb, 0);
    chk("nozero_after", rd_a_pl, 32'h1234);
    tick();

    // Bypass versus no bypass.
    set(1, 7, 32'h11, 3, 3, 0);
    tick();
    set(1, 7, 32'hA5A5A5A5, 7, 7, 0);
    chk("byp_same", rd_a_zb, 32'hA5A5A5A5);
    chk("nobyp_same", rd_a_pl, 32'h11);
    tick();
    set(0, 0, 0, 7, 7, 0);
    chk("nobyp_next", rd_a_pl, 32'hA5A5A5A5);
    chk("byp_next", rd_b_zb, 32'hA5A5A5A5);
    tick();

    // Fill, then full sweep with writes attempted throughout.
    for (int i = 0; i < DEPTH; i++) begin
      set(1, AW'(i), 32'hC0DE0000 + i * 32'h101 + 1, AW'(i), AW'(DEPTH - 1 - i), 0);
      tick();
    end
    set(0, 0, 0, 9, 31, 1);
    tick();
    busy_cnt = 0; done_cnt = 0; done_at = -1; ready_low = 0;
    for (int c = 1; c <= 34; c++) begin
      set(c <= 33, AW'($urandom_range(0, 31)), $urandom, AW'(c % 32), AW'((c + 16) % 32), 1'b0);
      if (clr_busy_zb) busy_cnt++;
      if (!wr_ready_zb) ready_low++;
      if (clr_done_zb) begin done_cnt++; done_at = c; end
      tick();
    end
    chk("sweep_busy_cycles", busy_cnt, 33);
    chk("sweep_ready_low",   ready_low, 33);
    chk("sweep_done_count",  done_cnt, 1);
    chk("sweep_done_cycle",  done_at, 33);
    for (int i = 0; i < DEPTH; i++) begin
      set(0, 0, 0, AW'(i), AW'(i), 0);
      chk("swept_pl", rd_a_pl, 0);
      tick();
    end

    // Sweep interrupted by reset, with a stray request mid-sweep.
    set(1, 9, 32'h99, 0, 0, 0);  tick();
    set(1, 20, 32'h2020, 0, 0, 0); tick();
    set(0, 0, 0, 9, 20, 1);
    tick();
    done_cnt = 0;
    for (int c = 1; c < 15; c++) begin
      set(0, 0, 0, 9, 20, c == 10);
      if (clr_done_zb || clr_done_pl) done_cnt++;
      tick();
    end
    chk("mid_busy", WIDTH'(clr_busy_zb), 1);
    rst_n = 1'b0;
    set(0, 0, 0, 9, 20, 0);
    chk("rst_mid_ready", WIDTH'(wr_ready_pl), 1);
    chk("rst_mid_busy",  WIDTH'(clr_busy_pl), 0);
    chk("rst_mid_rd_a",  rd_a_pl, 0);
    chk("rst_mid_rd_b",  rd_b_zb, 0);
    if (clr_done_zb || clr_done_pl) done_cnt++;
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 40; c++) begin
      set(0, 0, 0, 9, 20, 0);
      if (clr_done_zb || clr_done_pl) done_cnt++;
      tick();
    end
    chk("no_done_after_reset", done_cnt, 0);

    // Randomised traffic with occasional clears.
    for (int n = 0; n < 1500; n++) begin
      logic [AW-1:0] wa;
      wa = AW'($urandom_range(0, 31));
      set($urandom_range(0, 1), wa, $urandom,
          ($urandom_range(0, 3) == 0) ? wa : AW'($urandom_range(0, 31)),
          ($urandom_range(0, 3) == 0) ? wa : AW'($urandom_range(0, 31)),
          $urandom_range(0, 63) == 0);
      tick();
    end

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
